// File: rtl/mult4x4_cmpx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult4x4_cmpx_ctrl_pkg : shared state encoding, op indices and select decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult4x4_cmpx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MSTART = 3'd2,
        ST_MWAIT  = 3'd3,
        ST_FINISH = 3'd4,
        ST_ABORT  = 3'd5
    } state_e;

    localparam logic [1:0] OP_XZ = 2'd0;
    localparam logic [1:0] OP_YW = 2'd1;
    localparam logic [1:0] OP_XW = 2'd2;
    localparam logic [1:0] OP_YZ = 2'd3;

    typedef struct packed {
        logic sel1;
        logic sel2;
        logic sel3;
        logic sub;
    } sel_t;

    // Re accumulates xz - yw, Im accumulates xw + yz
    function automatic sel_t sel_decode(input logic [1:0] op);
        sel_t s;
        s.sel1 = op[0];
        s.sel2 = op[1] ^ op[0];
        s.sel3 = ~op[1];
        s.sub  = (op == OP_YW);
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmpx_wait_timer.sv
// ---------------------------------------------------------------------------
// cmpx_wait_timer : CW-bit wait counter, flags when the count reaches TIMEOUT-1
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmpx_wait_timer #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Flag is raised on the increment that lands on TIMEOUT-1
    assign tc = en && !clr && (cnt_d == TC_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult4x4_cmpx_ctrl.sv
// ---------------------------------------------------------------------------
// mult4x4_cmpx_ctrl : sequencer for (x+jy)(z+jw) on a shared real 4x4 multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult4x4_cmpx_ctrl
    import mult4x4_cmpx_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic done4x4,
    output logic ready,
    output logic done,
    output logic err,
    output logic ldx,
    output logic ldy,
    output logic ldz,
    output logic ldw,
    output logic sel1,
    output logic sel2,
    output logic sel3,
    output logic sub,
    output logic initR,
    output logic initI,
    output logic ldR,
    output logic ldI,
    output logic start4x4
);

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       tmr_clr, tmr_en, tmr_tc;
    sel_t       sel;

    cmpx_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sel      = sel_decode(op_q);
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        ldx      = 1'b0;
        ldy      = 1'b0;
        ldz      = 1'b0;
        ldw      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        sel3     = 1'b0;
        sub      = 1'b0;
        initR    = 1'b0;
        initI    = 1'b0;
        ldR      = 1'b0;
        ldI      = 1'b0;
        start4x4 = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                {ldx, ldy, ldz, ldw} = 4'b1111;
                initR   = 1'b1;
                initI   = 1'b1;
                op_d    = OP_XZ;
                state_d = ST_MSTART;
            end
            // done4x4 is deliberately not looked at here: it may still be high from the last product
            ST_MSTART: begin
                start4x4                = 1'b1;
                {sel1, sel2, sel3, sub} = sel;
                tmr_clr                 = 1'b1;
                state_d                 = ST_MWAIT;
            end
            ST_MWAIT: begin
                {sel1, sel2, sel3, sub} = sel;
                if (done4x4) begin
                    ldR = ~op_q[1];
                    ldI = op_q[1];
                    if (op_q == OP_YZ) begin
                        state_d = ST_FINISH;
                    end else begin
                        op_d    = op_q + 2'd1;
                        state_d = ST_MSTART;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_tc) state_d = ST_ABORT;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mult4x4_cmpx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult4x4_cmpx_ctrl : directed bench with a stub multiplier and datapath model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult4x4_cmpx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic done4x4;
    logic ready, done, err, ldx, ldy, ldz, ldw, sel1, sel2, sel3, sub;
    logic initR, initI, ldR, ldI, start4x4;

    logic start2 = 1'b0;
    logic done4x4_2 = 1'b0;
    logic t_ready, t_done, t_err, t_ldx, t_ldy, t_ldz, t_ldw, t_sel1, t_sel2, t_sel3, t_sub;
    logic t_initR, t_initI, t_ldR, t_ldI, t_start4x4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult4x4_cmpx_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .done4x4(done4x4),
        .ready(ready), .done(done), .err(err),
        .ldx(ldx), .ldy(ldy), .ldz(ldz), .ldw(ldw),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .sub(sub),
        .initR(initR), .initI(initI), .ldR(ldR), .ldI(ldI), .start4x4(start4x4)
    );

    mult4x4_cmpx_ctrl #(.TIMEOUT(8), .CW(4)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .done4x4(done4x4_2),
        .ready(t_ready), .done(t_done), .err(t_err),
        .ldx(t_ldx), .ldy(t_ldy), .ldz(t_ldz), .ldw(t_ldw),
        .sel1(t_sel1), .sel2(t_sel2), .sel3(t_sel3), .sub(t_sub),
        .initR(t_initR), .initI(t_initI), .ldR(t_ldR), .ldI(t_ldI), .start4x4(t_start4x4)
    );

    logic [15:0] o1, o2;
    assign o1 = {ready, done, err, ldx, ldy, ldz, ldw, sel1, sel2, sel3, sub,
                 initR, initI, ldR, ldI, start4x4};
    assign o2 = {t_ready, t_done, t_err, t_ldx, t_ldy, t_ldz, t_ldw, t_sel1, t_sel2, t_sel3, t_sub,
                 t_initR, t_initI, t_ldR, t_ldI, t_start4x4};

    // Stub multiplier: done4x4 on the dly-th cycle after start4x4, or held high
    int dly = 1;
    bit always_done = 1'b0;
    int mcnt = 0;
    assign done4x4 = always_done || (mcnt != 0 && mcnt == dly);

    always @(posedge clk) begin
        if (!rst)          mcnt <= 0;
        else if (done4x4)  mcnt <= 0;
        else if (start4x4) mcnt <= 1;
        else if (mcnt != 0) mcnt <= mcnt + 1;
    end

    // Datapath model: nibble operands, 8-bit wrapping accumulators
    logic [7:0] a_in = 8'h00, b_in = 8'h00;
    logic [3:0] x, y, z, w;
    logic [7:0] re, im, prod, acc, sum;
    assign prod = {4'b0, (sel1 ? y : x)} * {4'b0, (sel2 ? w : z)};
    assign acc  = sel3 ? re : im;
    assign sum  = sub ? acc - prod : acc + prod;

    always @(posedge clk) begin
        if (ldx) x <= a_in[7:4];
        if (ldy) y <= a_in[3:0];
        if (ldz) z <= b_in[7:4];
        if (ldw) w <= b_in[3:0];
        if (initR) re <= 8'h00; else if (ldR) re <= sum;
        if (initI) im <= 8'h00; else if (ldI) im <= sum;
    end

    logic [3:0] sel_log[$];
    logic [1:0] ld_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = cycles after the accepting edge until done is seen (-1 if never)
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int restart_at,
                          output int lat, output int dones, output int rdy_hi);
        a_in = a;
        b_in = b;
        sel_log.delete();
        ld_log.delete();
        lat = -1;
        dones = 0;
        rdy_hi = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            start = (i == restart_at);
            if (start4x4) sel_log.push_back({sel1, sel2, sel3, sub});
            if (ldR || ldI) ld_log.push_back({ldR, ldI});
            if (ready) rdy_hi++;
            if (done) begin
                dones++;
                lat = i;
                break;
            end
            tick();
        end
        start = 1'b0;
        tick();
        if (done) dones++;
    endtask

    int lat, dones, rdy_hi, ms, ei, errs, lds;

    initial begin
        #1;
        check("reset_outputs", {16'h0, o1}, 32'h8000);
        check("reset_outputs_to", {16'h0, o2}, 32'h8000);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // (3+j2)(1+j4) = -5 + j14
        dly = 1;
        run_op(8'h32, 8'h14, -1, lat, dones, rdy_hi);
        check("lat_k1", lat, 9);
        check("result_32_14", {16'h0, re, im}, 32'hFB0E);
        check("done_once", dones, 1);
        check("ready_low_busy", rdy_hi, 0);
        check("ready_after", {31'h0, ready}, 1);

        // Im = 225 + 225 wraps to 0xC2
        run_op(8'hFF, 8'hFF, -1, lat, dones, rdy_hi);
        check("result_ff_ff", {16'h0, re, im}, 32'h00C2);
        check("done_once_ff", dones, 1);

        // done4x4 held high throughout
        always_done = 1'b1;
        run_op(8'h32, 8'h14, -1, lat, dones, rdy_hi);
        check("lat_always", lat, 9);
        check("sel_count", sel_log.size(), 4);
        check("ld_count", ld_log.size(), 4);
        if (sel_log.size() == 4 && ld_log.size() == 4) begin
            check("sel_op0", {28'h0, sel_log[0]}, 4'b0010);
            check("sel_op1", {28'h0, sel_log[1]}, 4'b1111);
            check("sel_op2", {28'h0, sel_log[2]}, 4'b0100);
            check("sel_op3", {28'h0, sel_log[3]}, 4'b1000);
            check("ld_op0", {30'h0, ld_log[0]}, 2'b10);
            check("ld_op1", {30'h0, ld_log[1]}, 2'b10);
            check("ld_op2", {30'h0, ld_log[2]}, 2'b01);
            check("ld_op3", {30'h0, ld_log[3]}, 2'b01);
        end
        check("result_always", {16'h0, re, im}, 32'hFB0E);
        always_done = 1'b0;

        // Timeout on the TIMEOUT=8 instance
        ms = -1; ei = -1; errs = 0; lds = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (t_start4x4 && ms < 0) ms = i;
            if (t_err) begin
                errs++;
                if (ei < 0) ei = i;
            end
            if (t_ldR || t_ldI) lds++;
        end
        check("to_mstart_at", ms, 1);
        check("to_err_delay", ei - ms, 8);
        check("to_err_once", errs, 1);
        check("to_no_loads", lds, 0);
        check("to_ready_after", {31'h0, t_ready}, 1);

        // Slow multiplier, second start mid-operation ignored
        dly = 3;
        run_op(8'h32, 8'h14, 5, lat, dones, rdy_hi);
        check("lat_k3", lat, 17);
        check("done_once_k3", dones, 1);
        check("ready_low_k3", rdy_hi, 0);
        check("result_k3", {16'h0, re, im}, 32'hFB0E);
        lds = 0;
        for (int i = 0; i < 5; i++) begin
            if (!ready || ldx) lds++;
            tick();
        end
        check("no_requeue", lds, 0);

        // Async reset during op2 wait
        a_in = 8'hFF;
        b_in = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 11; i++) tick();
        check("pre_reset_op2_sel", {28'h0, sel1, sel2, sel3, sub}, 4'b0100);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {16'h0, o1}, 32'h8000);
        @(negedge clk);
        rst = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || err) errs++;
        end
        check("no_pulse_after_reset", errs, 0);
        check("ready_after_reset", {31'h0, ready}, 1);
        run_op(8'h32, 8'h14, -1, lat, dones, rdy_hi);
        check("post_reset_lat", lat, 17);
        check("post_reset_result", {16'h0, re, im}, 32'hFB0E);
        check("post_reset_done", dones, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
